id_rtype_stage: RTL
===================

Name: id_rtype_stage

Overview:
- Parametrised R-type decode stage with an ID/EX pipeline register.
- Accepts instructions from IF over valid/ready and decodes OP-opcode (0110011) instructions.
- Drives the register-file read ports and resolves operands by forwarding from the EX, MEM and WB stages.
- Detects load-use hazards and inserts a bubble. Presents a registered operand bundle to EX over valid/ready.

Parameters:
- DATA_WIDTH, 32, operand/register data width.
- RADDR_WIDTH, 5, register address width.
- INST_WIDTH, 32, instruction width (fields at standard RV32 bit positions).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  instruction valid from IF
- in_ready_o  out  1  stage can accept (combinational)
- inst_i  in  INST_WIDTH  instruction
- flush_i  in  1  kill contents (branch redirect)
- reg1_raddr_o, reg2_raddr_o  out  RADDR_WIDTH  regfile read addresses (combinational)
- reg1_re_o, reg2_re_o  out  1  regfile read enables (combinational)
- reg1_rdata_i, reg2_rdata_i  in  DATA_WIDTH  regfile read data (same cycle)
- ex_we_i, ex_load_i  in  1  EX writes rd / EX is a load
- ex_waddr_i  in  RADDR_WIDTH
- ex_wdata_i  in  DATA_WIDTH
- mem_we_i  in  1
- mem_waddr_i  in  RADDR_WIDTH
- mem_wdata_i  in  DATA_WIDTH
- wb_we_i  in  1
- wb_waddr_i  in  RADDR_WIDTH
- wb_wdata_i  in  DATA_WIDTH
- out_valid_o  out  1  bundle valid to EX (registered)
- out_ready_i  in  1  EX accepts
- op1_o, op2_o  out  DATA_WIDTH  resolved operands
- reg_we_o  out  1  write rd
- reg_waddr_o  out  RADDR_WIDTH  rd
- funct3_o  out  3
- alt_o  out  1  funct7[5] (SUB/SRA)
- muldiv_o  out  1  M-extension op
- illegal_o  out  1  malformed R-type

Behaviour:
- Reset (async, rst=1): all registered outputs are 0; out_valid_o=0. Mid-operation reset drops the held bundle immediately.
- Decode: is_r = (inst_i[6:0]==0110011). If in_valid_i && is_r: raddr1=rs1, raddr2=rs2, re1=re2=1. Otherwise raddr=0, re=0.
- Operand selection per source:
  - Priority: EX (ex_we_i && !ex_load_i && ex_waddr_i==rs && rs!=0), then MEM, then WB (same match rule), else regfile data.
  - rs==0 always yields 0.
- Hazard: hz = in_valid_i && is_r && ex_we_i && ex_load_i && ex_waddr_i!=0 && (ex_waddr_i==rs1 || ex_waddr_i==rs2).
- Advance: adv = !out_valid_o || out_ready_i. in_ready_o = adv && !hz.
- Register update, in priority order:
  - flush_i: out_valid_o←0. Input is consumed and discarded (in_ready_o unaffected).
  - Else if adv && hz: out_valid_o←0 (bubble). Input is held upstream.
  - Else if adv && in_valid_i: bundle captured; out_valid_o←1.
  - Else if adv: out_valid_o←0.
  - Else hold: all outputs stable while out_valid_o && !out_ready_i.
- Captured bundle:
  - R-type legal: reg_we_o=(rd!=0), reg_waddr_o=rd, op1/op2 forwarded values, funct3_o, alt_o=funct7[5], muldiv_o=(funct7==0000001), illegal_o=0.
  - Legal funct7 values: 0000000 (any funct3); 0100000 only with funct3 000 or 101; 0000001 per optional feature.
  - Illegal R-type: illegal_o=1, reg_we_o=0, operands 0, other fields as decoded.
  - Non-R-type: passes as a NOP bundle with all fields 0 and illegal_o=0.
- Latency: 1 cycle from accepted input to out_valid_o. Throughput: 1 per cycle when out_ready_i=1.

Optional Feature:
- Macro ID_RTYPE_M_EN.
- Defined: funct7=0000001 is legal with all funct3 values and sets muldiv_o=1.
- Undefined: funct7=0000001 is illegal (illegal_o=1, reg_we_o=0), and muldiv_o is tied to 0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), regfile x1=5, x2=7, no forwards, out_ready_i=1 → next cycle out_valid_o=1, op1=5, op2=7, reg_waddr=3, reg_we=1, funct3=0, alt=0.
- Same ADD with ex_we=1, ex_waddr=1, ex_wdata=0x11, mem_we=1, mem_waddr=1, mem_wdata=0x22, wb_we=1, wb_waddr=2, wb_wdata=0x33 → op1=0x11, op2=0x33. Repeat with rs=x0 and ex_waddr=0 → op=0.
- Load-use: ex_load=1, ex_we=1, ex_waddr=2, ADD pending → in_ready_o=0, next out_valid_o=0. After ex_load drops, ADD issues with the correct operands.
- Backpressure: out_ready_i=0 for 3 cycles while valid → outputs unchanged, in_ready_o=0. Release → next instruction captured the following cycle.
- SUB with funct3=001 (0x402091B3) → illegal_o=1, reg_we_o=0. MUL (0x022081B3): with ID_RTYPE_M_EN muldiv_o=1, illegal_o=0; without it illegal_o=1.
- flush_i asserted with valid input and a held bundle → out_valid_o=0 next cycle. rst pulsed mid-hold → out_valid_o=0 asynchronously.

Source files
------------

// File: rtl/id_rtype_stage.sv
// id_rtype_stage: R-type decode stage with ID/EX pipeline register.
// Decodes OP-opcode (0110011) instructions, drives the register-file read
// ports, resolves operands by forwarding from EX/MEM/WB, stalls on
// load-use hazards and presents a registered bundle to EX.
//
// Optional feature macro: ID_RTYPE_M_EN
//   defined   : funct7=0000001 (M extension) is legal and sets muldiv_o.
//   undefined : funct7=0000001 is illegal and muldiv_o is tied to 0.
//
// Handshake: a transfer happens on a rising clock edge when valid and
// ready are both high. in_ready_o is combinational. out_valid_o is
// registered, and the bundle stays stable while out_valid_o && !out_ready_i.
// flush_i consumes and discards the current input and kills the held bundle.
//
// Field positions follow RV32: rd at bit 7, rs1 at bit 15, rs2 at bit 20.
module id_rtype_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int INST_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [INST_WIDTH-1:0]  inst_i,
    input  logic                   flush_i,
    output logic [RADDR_WIDTH-1:0] reg1_raddr_o,
    output logic [RADDR_WIDTH-1:0] reg2_raddr_o,
    output logic                   reg1_re_o,
    output logic                   reg2_re_o,
    input  logic [DATA_WIDTH-1:0]  reg1_rdata_i,
    input  logic [DATA_WIDTH-1:0]  reg2_rdata_i,
    input  logic                   ex_we_i,
    input  logic                   ex_load_i,
    input  logic [RADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]  ex_wdata_i,
    input  logic                   mem_we_i,
    input  logic [RADDR_WIDTH-1:0] mem_waddr_i,
    input  logic [DATA_WIDTH-1:0]  mem_wdata_i,
    input  logic                   wb_we_i,
    input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [DATA_WIDTH-1:0]  wb_wdata_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  op1_o,
    output logic [DATA_WIDTH-1:0]  op2_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [2:0]             funct3_o,
    output logic                   alt_o,
    output logic                   muldiv_o,
    output logic                   illegal_o
);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Instruction fields
    logic [6:0]             opcode;
    logic [RADDR_WIDTH-1:0] rs1;
    logic [RADDR_WIDTH-1:0] rs2;
    logic [RADDR_WIDTH-1:0] rd;
    logic [2:0]             funct3;
    logic [6:0]             funct7;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[7 +: RADDR_WIDTH];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[15 +: RADDR_WIDTH];
    assign rs2    = inst_i[20 +: RADDR_WIDTH];
    assign funct7 = inst_i[31:25];

    logic                  is_r;
    logic                  legal;
    logic                  muldiv_dec;
    logic                  hz;
    logic                  adv;
    logic [DATA_WIDTH-1:0] fwd1;
    logic [DATA_WIDTH-1:0] fwd2;

    // Pick the youngest in-flight producer of a source register; a load in
    // EX has no data yet, so it is skipped here and handled as a stall.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [RADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]  rf_data
    );
        logic [DATA_WIDTH-1:0] val;
        val = rf_data;
        if (rs == '0) begin
            val = '0;
        end else if (ex_we_i && !ex_load_i && (ex_waddr_i == rs)) begin
            val = ex_wdata_i;
        end else if (mem_we_i && (mem_waddr_i == rs)) begin
            val = mem_wdata_i;
        end else if (wb_we_i && (wb_waddr_i == rs)) begin
            val = wb_wdata_i;
        end
        return val;
    endfunction

    // Decode, register-file read ports, legality and forwarding
    always_comb begin
        is_r         = (opcode == OPC_R);
        reg1_raddr_o = '0;
        reg2_raddr_o = '0;
        reg1_re_o    = 1'b0;
        reg2_re_o    = 1'b0;
        if (in_valid_i && is_r) begin
            reg1_raddr_o = rs1;
            reg2_raddr_o = rs2;
            reg1_re_o    = 1'b1;
            reg2_re_o    = 1'b1;
        end

`ifdef ID_RTYPE_M_EN
        muldiv_dec = (funct7 == F7_MULDIV);
`else
        muldiv_dec = 1'b0;
`endif
        legal = (funct7 == F7_BASE)
             || ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
             || muldiv_dec;

        fwd1 = resolve(rs1, reg1_rdata_i);
        fwd2 = resolve(rs2, reg2_rdata_i);
    end

    // Load-use stall and advance control
    always_comb begin
        hz = in_valid_i && is_r && ex_we_i && ex_load_i && (ex_waddr_i != '0)
          && ((ex_waddr_i == rs1) || (ex_waddr_i == rs2));
        adv        = !out_valid_o || out_ready_i;
        in_ready_o = adv && !hz;
    end

    // ID/EX pipeline register; empty slots carry an all-zero bundle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            funct3_o    <= '0;
            alt_o       <= 1'b0;
            muldiv_o    <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i || (adv && (hz || !in_valid_i))) begin
            out_valid_o <= 1'b0;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            funct3_o    <= '0;
            alt_o       <= 1'b0;
            muldiv_o    <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (adv) begin
            out_valid_o <= 1'b1;
            if (is_r) begin
                op1_o       <= legal ? fwd1 : '0;
                op2_o       <= legal ? fwd2 : '0;
                reg_we_o    <= legal && (rd != '0);
                reg_waddr_o <= rd;
                funct3_o    <= funct3;
                alt_o       <= funct7[5];
                muldiv_o    <= muldiv_dec;
                illegal_o   <= !legal;
            end else begin
                op1_o       <= '0;
                op2_o       <= '0;
                reg_we_o    <= 1'b0;
                reg_waddr_o <= '0;
                funct3_o    <= '0;
                alt_o       <= 1'b0;
                muldiv_o    <= 1'b0;
                illegal_o   <= 1'b0;
            end
        end
    end

endmodule
